// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the HI/LO unit: mt* operation codes, FSM states, default latencies.
// The MUL_ACC_EN macro enables the MADD/MADDU/MSUB accumulate operations.
package mul_div_unit_pkg;

   typedef enum logic [3:0] {
      mtDisabled         = 4'd0,
      mtMultiply         = 4'd1,
      mtMultiplyUnsigned = 4'd2,
      mtDivide           = 4'd3,
      mtDivideUnsigned   = 4'd4,
      mtSetHI            = 4'd5,
      mtSetLO            = 4'd6,
      mtMADD             = 4'd7,
      mtMADDU            = 4'd8,
      mtMSUB             = 4'd9
   } mt_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;

   // Codes that occupy the unit for multiple cycles; accumulate ops only when built in.
   function automatic logic is_arith(input logic [3:0] op);
      logic r;
      r = 1'b0;
      case (op)
         mtMultiply, mtMultiplyUnsigned, mtDivide, mtDivideUnsigned: r = 1'b1;
`ifdef MUL_ACC_EN
         mtMADD, mtMADDU, mtMSUB: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == mtDivide) || (op == mtDivideUnsigned);
   endfunction

endpackage

// File: rtl/mul_div_unit_core.sv
// Combinational datapath: 64-bit product, quotient/remainder, and (with MUL_ACC_EN)
// the multiply-accumulate adder. Output is {HI, LO}.
module mul_div_core
   import mul_div_unit_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [63:0] i_acc,
   output logic [63:0] o_res
);

   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic signed [31:0] w_a_s;
   logic signed [31:0] w_bs_safe;
   logic        [31:0] w_bu_safe;
   logic        [31:0] w_q_s;
   logic        [31:0] w_r_s;
   logic        [31:0] w_q_u;
   logic        [31:0] w_r_u;
   logic               w_b_zero;
   logic               w_div_ovf;

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   assign w_b_zero  = (i_b == 32'd0);
   assign w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

   // Dividing the overflow case by +1 yields exactly 0x80000000 rem 0, and avoids /0 in sim.
   assign w_a_s     = $signed(i_a);
   assign w_bs_safe = (w_b_zero || w_div_ovf) ? 32'sd1 : $signed(i_b);
   assign w_bu_safe = w_b_zero ? 32'd1 : i_b;

   assign w_q_s = w_a_s / w_bs_safe;
   assign w_r_s = w_a_s % w_bs_safe;
   assign w_q_u = i_a / w_bu_safe;
   assign w_r_u = i_a % w_bu_safe;

   always_comb begin
      o_res = i_acc;
      case (i_op)
         mtMultiply:         o_res = $unsigned(w_prod_s);
         mtMultiplyUnsigned: o_res = w_prod_u;
         mtDivide:           o_res = w_b_zero ? {i_a, 32'hFFFF_FFFF} : {w_r_s, w_q_s};
         mtDivideUnsigned:   o_res = w_b_zero ? {i_a, 32'hFFFF_FFFF} : {w_r_u, w_q_u};
`ifdef MUL_ACC_EN
         mtMADD:             o_res = i_acc + $unsigned(w_prod_s);
         mtMADDU:            o_res = i_acc + w_prod_u;
         mtMSUB:             o_res = i_acc - $unsigned(w_prod_s);
`endif
         default:            o_res = i_acc;
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with busy stall flag and mfhi/mflo read mux.
// Define MUL_ACC_EN to build in MADD/MADDU/MSUB.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  ctrl,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic        outputSel,
   output logic        busy,
   output logic [31:0] result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   md_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [3:0]       r_op;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   logic             w_accept;
   logic [63:0]      w_core_res;

   assign w_accept = start && !r_busy;

   mul_div_core u_core (
      .i_op  (r_op),
      .i_a   (r_a),
      .i_b   (r_b),
      .i_acc ({r_hi, r_lo}),
      .o_res (w_core_res)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_op    <= mtDisabled;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (ctrl == mtSetHI) begin
                     r_hi <= operandA;
                  end else if (ctrl == mtSetLO) begin
                     r_lo <= operandA;
                  end else if (is_arith(ctrl)) begin
                     r_op    <= ctrl;
                     r_a     <= operandA;
                     r_b     <= operandB;
                     r_cnt   <= is_div(ctrl) ? DIV_LOAD : MUL_LOAD;
                     r_busy  <= 1'b1;
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // HI/LO hold steady during RUN, so the accumulate base equals the accept-time value.
               if (r_cnt == '0) begin
                  r_hi    <= w_core_res[63:32];
                  r_lo    <= w_core_res[31:0];
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign hi     = r_hi;
   assign lo     = r_lo;
   assign result = outputSel ? r_hi : r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (default latencies 5/10).
`timescale 1ns/1ps
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  ctrl;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        outputSel;
   logic        busy;
   logic [31:0] result;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ctrl      (ctrl),
      .operandA  (operandA),
      .operandB  (operandB),
      .outputSel (outputSel),
      .busy      (busy),
      .result    (result),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; ctrl = c; operandA = a; operandB = b;
      tick();
      start = 1'b0; ctrl = mtDisabled;
   endtask

   task automatic run_out(output int n);
      n = 0;
      while (busy && n < 64) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; ctrl = mtDisabled;
      operandA = '0; operandB = '0; outputSel = 1'b0;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_multu();
      int n;
      issue(mtMultiplyUnsigned, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      operandA = 32'd3; operandB = 32'd3;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy got %0b want 1", busy); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL multu_prehold got %h/%h want 0/0", hi, lo); end
      run_out(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL multu_cycles got %0d want 5", n); end
      checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_val got %h/%h want fffffffe/00000001", hi, lo); end
   endtask

   task automatic test_mult_signed();
      int n;
      issue(mtMultiply, 32'hFFFF_FFFD, 32'd5);
      run_out(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL mult_cycles got %0d want 5", n); end
      checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_val got %h/%h want ffffffff/fffffff1", hi, lo); end
   endtask

   task automatic test_divide();
      int n;
      issue(mtDivide, 32'hFFFF_FFF9, 32'd2);
      run_out(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div_cycles got %0d want 10", n); end
      checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg got lo=%h hi=%h want fffffffd/ffffffff", lo, hi); end
      issue(mtDivide, 32'd5, 32'd0);
      run_out(n);
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin errors++; $display("FAIL div_zero got lo=%h hi=%h want ffffffff/00000005", lo, hi); end
      issue(mtDivideUnsigned, 32'hFFFF_FFF9, 32'd2);
      run_out(n);
      checks++; if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin errors++; $display("FAIL divu_val got lo=%h hi=%h want 7ffffffc/00000001", lo, hi); end
      issue(mtDivideUnsigned, 32'h0000_1234, 32'd0);
      run_out(n);
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin errors++; $display("FAIL divu_zero got lo=%h hi=%h want ffffffff/00001234", lo, hi); end
      issue(mtDivide, 32'h8000_0000, 32'hFFFF_FFFF);
      run_out(n);
      checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin errors++; $display("FAIL div_ovf got lo=%h hi=%h want 80000000/00000000", lo, hi); end
   endtask

   task automatic test_select();
      issue(mtSetHI, 32'h0000_DEAD, 32'd0);
      checks++; if (busy !== 1'b0 || hi !== 32'h0000_DEAD) begin errors++; $display("FAIL mthi got busy=%0b hi=%h want 0/0000dead", busy, hi); end
      issue(mtSetLO, 32'h0000_BEEF, 32'd0);
      checks++; if (lo !== 32'h0000_BEEF || hi !== 32'h0000_DEAD) begin errors++; $display("FAIL mtlo got hi=%h lo=%h want 0000dead/0000beef", hi, lo); end
      outputSel = 1'b1; #1;
      checks++; if (result !== 32'h0000_DEAD) begin errors++; $display("FAIL sel_hi got %h want 0000dead", result); end
      outputSel = 1'b0; #1;
      checks++; if (result !== 32'h0000_BEEF) begin errors++; $display("FAIL sel_lo got %h want 0000beef", result); end
   endtask

   task automatic test_stall();
      int n;
      issue(mtMultiply, 32'd3, 32'd4);
      start = 1'b1; ctrl = mtSetHI; operandA = 32'h0000_1234; operandB = '0;
      n = 0;
      while (busy && n < 64) begin
         n++;
         tick();
      end
      checks++; if (n !== 5 || hi !== 32'd0 || lo !== 32'd12) begin errors++; $display("FAIL stall_ignored got n=%0d hi=%h lo=%h want 5/0/c", n, hi, lo); end
      tick();
      start = 1'b0; ctrl = mtDisabled;
      checks++; if (hi !== 32'h0000_1234 || busy !== 1'b0) begin errors++; $display("FAIL stall_retry got hi=%h busy=%0b want 00001234/0", hi, busy); end
   endtask

   task automatic test_reset_mid();
      issue(mtSetLO, 32'h0000_00AA, 32'd0);
      issue(mtDivideUnsigned, 32'd100, 32'd7);
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
      tick();
      reset = 1'b0;
      repeat (15) tick();
      checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_nocommit got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
   endtask

   task automatic test_noop();
      issue(mtSetHI, 32'h0000_0011, 32'd0);
      issue(mtSetLO, 32'h0000_0022, 32'd0);
      issue(mtDisabled, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL noop_dis got busy=%0b hi=%h lo=%h want 0/11/22", busy, hi, lo); end
      issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL noop_unk got busy=%0b hi=%h lo=%h want 0/11/22", busy, hi, lo); end
   endtask

   task automatic test_madd();
      int n;
      issue(mtSetHI, 32'd0, 32'd0);
      issue(mtSetLO, 32'hFFFF_FFFF, 32'd0);
      issue(mtMADDU, 32'd1, 32'd1);
`ifdef MUL_ACC_EN
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL maddu_busy got %0b want 1", busy); end
      run_out(n);
      checks++; if (n !== 5 || hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL maddu_val got n=%0d hi=%h lo=%h want 5/1/0", n, hi, lo); end
      issue(mtMSUB, 32'd2, 32'd1);
      run_out(n);
      checks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL msub_val got hi=%h lo=%h want 0/fffffffe", hi, lo); end
`else
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL maddu_nobusy got %0b want 0", busy); end
      run_out(n);
      tick();
      checks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL maddu_noop got hi=%h lo=%h want 0/ffffffff", hi, lo); end
      issue(mtMSUB, 32'd2, 32'd1);
      checks++; if (busy !== 1'b0 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msub_noop got busy=%0b lo=%h want 0/ffffffff", busy, lo); end
`endif
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult_signed();
      test_divide();
      test_select();
      test_stall();
      test_reset_mid();
      test_noop();
      test_madd();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
